// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: groups pipeline hazard inputs and stall/flush outputs.
//   master : pipeline side, drives register IDs, load/branch/memory status
//   slave  : hazard_ctrl, returns stall/flush/bubble/PCWrite, state and counters
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       ID_rs1_i;
  logic [4:0]       ID_rs2_i;
  logic [4:0]       EX_rd_i;
  logic             EX_MemRead_i;
  logic             branch_taken_i;
  logic             mem_req_i;
  logic             mem_ready_i;
  logic             stall_o;
  logic             stall2_o;
  logic             flush_o;
  logic             PCWrite_o;
  logic             bubble_o;
  logic [1:0]       state_o;
  logic             err_o;
  logic [CNT_W-1:0] stall_cycles_o;
  logic [CNT_W-1:0] flush_count_o;

  modport master (
    output ID_rs1_i, ID_rs2_i, EX_rd_i, EX_MemRead_i, branch_taken_i,
           mem_req_i, mem_ready_i,
    input  stall_o, stall2_o, flush_o, PCWrite_o, bubble_o, state_o, err_o,
           stall_cycles_o, flush_count_o
  );

  modport slave (
    input  ID_rs1_i, ID_rs2_i, EX_rd_i, EX_MemRead_i, branch_taken_i,
           mem_req_i, mem_ready_i,
    output stall_o, stall2_o, flush_o, PCWrite_o, bubble_o, state_o, err_o,
           stall_cycles_o, flush_count_o
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and stall sequencer for the 5-stage core front end.
// Priority: data-memory wait, then load-use, then taken branch.
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous reset, active-low
//   bus    : hazard_ctrl_if.slave (hazard inputs, stall/flush/PCWrite/bubble,
//            FSM state, sticky timeout error, saturating perf counters)
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  hazard_ctrl_if.slave  bus
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_ABORT    = 2'd2;

  localparam int unsigned    WC_W    = $clog2(MEM_TIMEOUT);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic             pend_flush_q, pend_flush_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  logic mem_wait, load_use, stall, stall2, flush, pcwrite;

  always_comb begin
    mem_wait = bus.mem_req_i & ~bus.mem_ready_i;
    load_use = bus.EX_MemRead_i & (bus.EX_rd_i != '0) &
               ((bus.EX_rd_i == bus.ID_rs1_i) | (bus.EX_rd_i == bus.ID_rs2_i));
    stall2   = ((state_q == ST_RUN) & mem_wait) |
               ((state_q == ST_MEM_WAIT) & ~bus.mem_ready_i);
    stall    = load_use & ~stall2;
    // A load-use stall defers the branch: ID re-resolves it next cycle with
    // the forwarded operand, so no flush is raised here.
    flush    = (bus.branch_taken_i | pend_flush_q) & ~stall2 & ~stall;
    pcwrite  = ~(stall | stall2);
  end

  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    err_d          = err_q;
    pend_flush_d   = pend_flush_q;
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;

    // A branch that resolves while memory holds the pipe is replayed as a
    // flush once the stall releases.
    if (bus.branch_taken_i & stall2) begin
      pend_flush_d = 1'b1;
    end else if (flush) begin
      pend_flush_d = 1'b0;
    end

    case (state_q)
      ST_RUN: begin
        if (mem_wait) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = WC_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (bus.mem_ready_i) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WC_LAST) begin
          state_d    = ST_ABORT;
          wait_cnt_d = '0;
          err_d      = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WC_W'(1);
        end
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase

    if ((stall | stall2) && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
    if (flush && (flush_count_q != '1)) begin
      flush_count_d = flush_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q        <= ST_RUN;
      wait_cnt_q     <= '0;
      pend_flush_q   <= 1'b0;
      err_q          <= 1'b0;
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      pend_flush_q   <= pend_flush_d;
      err_q          <= err_d;
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  // Control outputs are held inactive for the whole reset window.
  assign bus.stall_o        = rst_i & stall;
  assign bus.stall2_o       = rst_i & stall2;
  assign bus.flush_o        = rst_i & flush;
  assign bus.bubble_o       = rst_i & stall;
  assign bus.PCWrite_o      = rst_i & pcwrite;
  assign bus.state_o        = state_q;
  assign bus.err_o          = err_q;
  assign bus.stall_cycles_o = stall_cycles_q;
  assign bus.flush_count_o  = flush_count_q;

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and stall sequencer for the 5-stage core front end.
- Generates stall, flush and stall2 for the IF/ID register, PCWrite for the PC, and bubble insertion for ID/EX.
- Arbitrates three hazard sources in priority order: data-memory wait, then load-use, then taken branch.
- Keeps saturating performance counters and a sticky memory-timeout error.

Parameters:
MEM_TIMEOUT, 64, max consecutive MEM_WAIT cycles before forced abort (>=2)
CNT_W, 16, width of performance counters

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous reset, active-low
ID_rs1_i  in  5  rs1 of instruction in ID
ID_rs2_i  in  5  rs2 of instruction in ID
EX_rd_i  in  5  rd of instruction in EX
EX_MemRead_i  in  1  instruction in EX is a load
branch_taken_i  in  1  ID-stage branch resolved taken
mem_req_i  in  1  MEM stage issuing load/store this cycle
mem_ready_i  in  1  data memory completes access this cycle
stall_o  out  1  load-use stall to IF/ID
stall2_o  out  1  memory-wait stall to all pipeline registers
flush_o  out  1  zero IF/ID instruction
PCWrite_o  out  1  PC update enable
bubble_o  out  1  zero ID/EX control signals
state_o  out  2  FSM state (0 RUN, 1 MEM_WAIT, 2 ABORT)
err_o  out  1  sticky timeout flag
stall_cycles_o  out  CNT_W  cycles with stall_o or stall2_o high, saturating
flush_count_o  out  CNT_W  cycles with flush_o high, saturating

Behaviour:
- Reset: rst_i low asynchronously sets state=RUN, pend_flush=0, wait_cnt=0, err_o=0, both counters=0.
- While rst_i is low, combinational outputs are forced to stall_o=0, stall2_o=0, flush_o=0, bubble_o=0, PCWrite_o=0.
- Control outputs are combinational from the registered state plus current inputs, so IF/ID samples them at the same edge. FSM, pend_flush and counters update on posedge clk_i.
- mem_wait = mem_req_i & ~mem_ready_i.
- stall2_o = (state==RUN & mem_wait) | (state==MEM_WAIT & ~mem_ready_i). stall2_o is always 0 in ABORT.
- load_use = EX_MemRead_i & EX_rd_i!=0 & (EX_rd_i==ID_rs1_i | EX_rd_i==ID_rs2_i). Register x0 never hazards.
- stall_o = load_use & ~stall2_o. bubble_o = stall_o.
- flush_o = (branch_taken_i | pend_flush) & ~stall2_o & ~stall_o.
  - Load-use wins over branch: the branch operand is stale, so ID re-resolves the branch next cycle.
- PCWrite_o = ~(stall_o | stall2_o). A flush still allows the PC write, because the PC loads the branch target.
- pend_flush:
  - Set when branch_taken_i & stall2_o.
  - Cleared in any cycle where flush_o=1.
  - Guarantees a branch resolved during a memory wait is not lost.
- FSM transitions:
  - RUN -> MEM_WAIT on mem_wait. wait_cnt <= 1.
  - MEM_WAIT -> RUN on mem_ready_i. wait_cnt <= 0.
  - MEM_WAIT, ~mem_ready_i, wait_cnt==MEM_TIMEOUT-1 -> ABORT. err_o <= 1.
  - MEM_WAIT otherwise: wait_cnt++.
  - ABORT -> RUN unconditionally after 1 cycle. In ABORT, stall2_o=0 so the pipeline drains. err_o stays 1 until reset.
  - mem_ready_i in the same cycle as mem_req_i in RUN: no wait, state stays RUN.
- Counters:
  - stall_cycles_o increments when stall_o|stall2_o.
  - flush_count_o increments when flush_o.
  - Both hold at 2^CNT_W-1 (no wrap).
- Reset asserted mid-MEM_WAIT: immediate return to RUN. pend_flush is lost (intended).

Test Plan:
- Load-use: EX_MemRead_i=1, EX_rd_i=5, ID_rs2_i=5, no mem/branch -> stall_o=1, bubble_o=1, PCWrite_o=0, flush_o=0 for 1 cycle. Repeat with EX_rd_i=0 -> stall_o=0.
- Memory wait: mem_req_i=1, mem_ready_i low 3 cycles then high -> stall2_o=1 for 3 cycles, state_o 0->1->1->1->0, stall_cycles_o=3.
- Branch during wait: branch_taken_i pulsed on 2nd wait cycle -> flush_o=0 while stalled. flush_o=1 in exactly the first cycle after mem_ready_i. flush_count_o=1.
- Branch + load-use same cycle -> flush_o=0, stall_o=1. Next cycle, load_use clear and branch_taken_i=1 -> flush_o=1, PCWrite_o=1.
- Timeout with MEM_TIMEOUT=4: mem_ready_i held low -> stall2_o high 4 cycles, state_o=2 for 1 cycle with stall2_o=0, err_o=1 and remains 1 until rst_i low.
- Saturation with CNT_W=4: 20 continuous stall cycles -> stall_cycles_o=15. Async reset mid-MEM_WAIT -> all outputs and counters 0 without a clock edge.
